// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared widths, entry layout and FSM encoding for the BTB write side
package btb_pkg;

    localparam int PC_W    = 13;
    localparam int IDX_W   = 11;
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int ENTRY_W = 1 + TAG_W + PC_W;

    localparam int VALID_BIT = 15;
    localparam int TAG_HI    = 14;
    localparam int TAG_LO    = 13;
    localparam int TGT_HI    = 12;
    localparam int TGT_LO    = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } btb_state_t;

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [PC_W-1:0] pc,
                                                      input logic [PC_W-1:0] target);
        logic [ENTRY_W-1:0] e;
        e                  = '0;
        e[VALID_BIT]       = 1'b1;
        e[TAG_HI:TAG_LO]   = pc[PC_W-1:IDX_W];
        e[TGT_HI:TGT_LO]   = target;
        return e;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - dual-push, single-pop FIFO of pending {pc, target} BTB updates
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             push0,
    input  logic [PC_W-1:0]  push0_pc,
    input  logic [PC_W-1:0]  push0_target,
    input  logic             push1,
    input  logic [PC_W-1:0]  push1_pc,
    input  logic [PC_W-1:0]  push1_target,
    input  logic             pop,
    output logic [PC_W-1:0]  head_pc,
    output logic [PC_W-1:0]  head_target,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             one_free
);

    logic [2*PC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;

    // The caller only pushes into free slots; push1 lands behind push0 when both fire.
    assign pop_ok      = pop && (count != '0);
    assign head_pc     = mem[rd_ptr][2*PC_W-1:PC_W];
    assign head_target = mem[rd_ptr][PC_W-1:0];
    assign full        = (count == CNT_W'(DEPTH));
    assign one_free    = (count == CNT_W'(DEPTH - 1));

    always_ff @(posedge CLK) begin
        if (!flush) begin
            if (push0)
                mem[wr_ptr] <= {push0_pc, push0_target};
            if (push1)
                mem[wr_ptr + PTR_W'(push0)] <= {push1_pc, push1_target};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr <= rd_ptr + PTR_W'(pop_ok);
            count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - arbitrates decode/execute target updates and invalidate walks onto the BTB write port
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               updD_valid,
    input  logic [PC_W-1:0]    updD_pc,
    input  logic [PC_W-1:0]    updD_target,
    input  logic               updE_valid,
    input  logic [PC_W-1:0]    updE_pc,
    input  logic [PC_W-1:0]    updE_target,
    input  logic               inv_req,
    output logic               wen,
    output logic [IDX_W-1:0]   w_addr,
    output logic [ENTRY_W-1:0] w_data,
    output logic               busy,
    output logic [7:0]         drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    btb_state_t         state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               wen_n, busy_n;
    logic [IDX_W-1:0]   w_addr_n;
    logic [ENTRY_W-1:0] w_data_n;
    logic [7:0]         drop_n;
    logic [1:0]         drop_inc;
    logic [8:0]         drop_sum;

    logic               push0, push1, pop, flush;
    logic [PC_W-1:0]    push0_pc, push0_target;
    logic [PC_W-1:0]    head_pc, head_target;
    logic [CNT_W-1:0]   count;
    logic               full, one_free;
    logic               e_ok, d_ok;

    // A decode update for the same PC as the execute update is redundant, not a drop.
    assign e_ok = updE_valid;
    assign d_ok = updD_valid && !(updE_valid && (updE_pc == updD_pc));

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK          (CLK),
        .RST          (RST),
        .flush        (flush),
        .push0        (push0),
        .push0_pc     (push0_pc),
        .push0_target (push0_target),
        .push1        (push1),
        .push1_pc     (updD_pc),
        .push1_target (updD_target),
        .pop          (pop),
        .head_pc      (head_pc),
        .head_target  (head_target),
        .count        (count),
        .full         (full),
        .one_free     (one_free)
    );

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        wen_n        = 1'b0;
        w_addr_n     = w_addr;
        w_data_n     = w_data;
        busy_n       = busy;
        push0        = 1'b0;
        push1        = 1'b0;
        push0_pc     = e_ok ? updE_pc : updD_pc;
        push0_target = e_ok ? updE_target : updD_target;
        pop          = 1'b0;
        flush        = 1'b0;
        drop_inc     = 2'd0;

        case (state)
            ST_CLEAR: begin
                if (inv_req) begin
                    idx_n = '0;
                end else begin
                    wen_n    = 1'b1;
                    w_addr_n = idx;
                    w_data_n = '0;
                    idx_n    = idx + 1'b1;
                    if (idx == IDX_W'(ENTRIES - 1)) begin
                        state_n = ST_RUN;
                        busy_n  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (inv_req) begin
                    flush   = 1'b1;
                    idx_n   = '0;
                    state_n = ST_CLEAR;
                    busy_n  = 1'b1;
                end else begin
                    if (count != '0) begin
                        pop      = 1'b1;
                        wen_n    = 1'b1;
                        w_addr_n = head_pc[IDX_W-1:0];
                        w_data_n = make_entry(head_pc, head_target);
                    end
                    // Room is judged on the pre-pop occupancy; E always takes the first slot.
                    if (e_ok && d_ok) begin
                        push0    = !full;
                        push1    = !full && !one_free;
                        drop_inc = full ? 2'd2 : (one_free ? 2'd1 : 2'd0);
                    end else if (e_ok || d_ok) begin
                        push0    = !full;
                        drop_inc = full ? 2'd1 : 2'd0;
                    end
                end
            end
            default: begin
                state_n = ST_CLEAR;
                idx_n   = '0;
                busy_n  = 1'b1;
            end
        endcase

        drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};
        drop_n   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_CLEAR;
            idx      <= '0;
            wen      <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            busy     <= 1'b1;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            wen      <= wen_n;
            w_addr   <= w_addr_n;
            w_data   <= w_data_n;
            busy     <= busy_n;
            drop_cnt <= drop_n;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;
    import btb_pkg::*;

    localparam int DEPTH = 4;

    logic               CLK = 1'b0;
    logic               RST;
    logic               updD_valid, updE_valid, inv_req;
    logic [PC_W-1:0]    updD_pc, updD_target, updE_pc, updE_target;
    logic               wen, busy;
    logic [IDX_W-1:0]   w_addr;
    logic [ENTRY_W-1:0] w_data;
    logic [7:0]         drop_cnt;

    int tests = 0;
    int fails = 0;

    btb_update_ctrl #(.DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .updD_valid  (updD_valid),
        .updD_pc     (updD_pc),
        .updD_target (updD_target),
        .updE_valid  (updE_valid),
        .updE_pc     (updE_pc),
        .updE_target (updE_target),
        .inv_req     (inv_req),
        .wen         (wen),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: a queue of pending updates plus the walk position.
    int m_q_pc[$];
    int m_q_tg[$];
    bit m_run;
    int m_idx;
    bit e_wen, e_busy;
    int e_addr, e_data, e_drop;
    int wr_addr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q_pc.delete();
        m_q_tg.delete();
        m_run  = 1'b0;
        m_idx  = 0;
        e_wen  = 1'b0;
        e_busy = 1'b1;
        e_addr = 0;
        e_data = 0;
        e_drop = 0;
    endtask

    task automatic model_edge(input bit ev, input int epc, input int et,
                              input bit dv, input int dpc, input int dt, input bit inv);
        int room;
        int pc, tg;
        int cand_pc[$];
        int cand_tg[$];
        if (!m_run) begin
            if (inv) begin
                e_wen = 1'b0;
                m_idx = 0;
            end else begin
                e_wen  = 1'b1;
                e_addr = m_idx;
                e_data = 0;
                if (m_idx == ENTRIES - 1) begin
                    m_run  = 1'b1;
                    e_busy = 1'b0;
                end
                m_idx = (m_idx + 1) % ENTRIES;
            end
        end else if (inv) begin
            m_q_pc.delete();
            m_q_tg.delete();
            e_wen  = 1'b0;
            m_run  = 1'b0;
            m_idx  = 0;
            e_busy = 1'b1;
        end else begin
            room = DEPTH - m_q_pc.size();
            if (m_q_pc.size() > 0) begin
                pc     = m_q_pc.pop_front();
                tg     = m_q_tg.pop_front();
                e_wen  = 1'b1;
                e_addr = pc % ENTRIES;
                e_data = 32768 + (pc / ENTRIES) * 8192 + tg;
            end else begin
                e_wen = 1'b0;
            end
            if (ev) begin cand_pc.push_back(epc); cand_tg.push_back(et); end
            if (dv && !(ev && dpc == epc)) begin cand_pc.push_back(dpc); cand_tg.push_back(dt); end
            foreach (cand_pc[k]) begin
                if (room > 0) begin
                    m_q_pc.push_back(cand_pc[k]);
                    m_q_tg.push_back(cand_tg[k]);
                    room--;
                end else if (e_drop < 255) begin
                    e_drop++;
                end
            end
        end
    endtask

    task automatic step(input bit ev, input logic [12:0] epc, input logic [12:0] et,
                        input bit dv, input logic [12:0] dpc, input logic [12:0] dt, input bit inv);
        updE_valid  = ev;
        updE_pc     = epc;
        updE_target = et;
        updD_valid  = dv;
        updD_pc     = dpc;
        updD_target = dt;
        inv_req     = inv;
        @(posedge CLK);
        model_edge(ev, int'(epc), int'(et), dv, int'(dpc), int'(dt), inv);
        @(negedge CLK);
        if (wen === 1'b1) wr_addr.push_back(int'(w_addr));
        chk("m_wen", wen, e_wen);
        if (e_wen) begin
            chk("m_addr", w_addr, e_addr);
            chk("m_data", w_data, e_data);
        end
        chk("m_busy", busy, e_busy);
        chk("m_drop", drop_cnt, e_drop);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rand_step();
        logic [12:0] a, b;
        a = 13'(($urandom % 4) * 2048 + ($urandom % 8));
        b = 13'(($urandom % 4) * 2048 + ($urandom % 8));
        step(($urandom % 4) != 0, a, 13'($urandom), ($urandom % 4) != 0, b, 13'($urandom), 1'b0);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_wen"},  wen, 0);
        chk({tag, "_addr"}, w_addr, 0);
        chk({tag, "_data"}, w_data, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_drop"}, drop_cnt, 0);
    endtask

    task automatic walk_check(input string tag, input bit traffic);
        for (int i = 0; i < ENTRIES; i++) begin
            if (traffic) rand_step(); else idle();
            chk({tag, "_wen"},  wen, 1);
            chk({tag, "_addr"}, w_addr, i);
            chk({tag, "_data"}, w_data, 0);
            chk({tag, "_busy"}, busy, (i == ENTRIES - 1) ? 0 : 1);
        end
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2 RST = 1'b1;
        #1 reset_vals(tag);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    typedef struct {
        bit          ev;
        logic [12:0] epc, et;
        bit          dv;
        logic [12:0] dpc, dt;
        bit          xw;
        logic [10:0] xa;
        logic [15:0] xd;
        logic [7:0]  xdrop;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 13'h1A05, 13'h0123, 1'b0, 13'h0000, 13'h0000, 1'b0, 11'h000, 16'h0000, 8'd0};
        vt[1] = '{1'b0, 13'h0000, 13'h0000, 1'b0, 13'h0000, 13'h0000, 1'b1, 11'h205, 16'hE123, 8'd0};
        vt[2] = '{1'b1, 13'h0004, 13'h0100, 1'b1, 13'h0008, 13'h0200, 1'b0, 11'h000, 16'h0000, 8'd0};
        vt[3] = '{1'b0, 13'h0000, 13'h0000, 1'b0, 13'h0000, 13'h0000, 1'b1, 11'h004, 16'h8100, 8'd0};
        vt[4] = '{1'b0, 13'h0000, 13'h0000, 1'b0, 13'h0000, 13'h0000, 1'b1, 11'h008, 16'h8200, 8'd0};
        vt[5] = '{1'b0, 13'h0000, 13'h0000, 1'b0, 13'h0000, 13'h0000, 1'b0, 11'h000, 16'h0000, 8'd0};
        vt[6] = '{1'b1, 13'h0010, 13'h0111, 1'b1, 13'h0010, 13'h0222, 1'b0, 11'h000, 16'h0000, 8'd0};
        vt[7] = '{1'b0, 13'h0000, 13'h0000, 1'b0, 13'h0000, 13'h0000, 1'b1, 11'h010, 16'h8111, 8'd0};
        vt[8] = '{1'b0, 13'h0000, 13'h0000, 1'b0, 13'h0000, 13'h0000, 1'b0, 11'h000, 16'h0000, 8'd0};

        RST = 1'b1;
        updE_valid = 1'b0; updE_pc = '0; updE_target = '0;
        updD_valid = 1'b0; updD_pc = '0; updD_target = '0;
        inv_req = 1'b0;
        model_reset();
        @(negedge CLK);
        reset_vals("reset");
        @(negedge CLK);
        RST = 1'b0;

        walk_check("walk1", 1'b0);
        idle();
        chk("walk1_end_wen", wen, 0);

        foreach (vt[i]) begin
            step(vt[i].ev, vt[i].epc, vt[i].et, vt[i].dv, vt[i].dpc, vt[i].dt, 1'b0);
            chk($sformatf("vec%0d_wen", i), wen, vt[i].xw);
            if (vt[i].xw) begin
                chk($sformatf("vec%0d_addr", i), w_addr, vt[i].xa);
                chk($sformatf("vec%0d_data", i), w_data, vt[i].xd);
            end
            chk($sformatf("vec%0d_drop", i), drop_cnt, vt[i].xdrop);
        end

        // E held for 7 cycles alongside a distinct D each cycle.
        wr_addr.delete();
        for (int i = 0; i < 7; i++)
            step(1'b1, 13'(13'h0100 + i), 13'(13'h0050 + i), 1'b1, 13'(13'h0700 + i), 13'(13'h0060 + i), 1'b0);
        for (int i = 0; i < 6; i++) idle();
        chk("collide_drop", drop_cnt, 5);
        chk("collide_nwr", wr_addr.size(), 9);
        begin
            int exp_order[9] = '{'h100, 'h700, 'h101, 'h701, 'h102, 'h103, 'h104, 'h105, 'h106};
            foreach (exp_order[k])
                if (k < wr_addr.size()) chk($sformatf("collide_ord%0d", k), wr_addr[k], exp_order[k]);
        end

        // Three pending entries, then invalidate; traffic during the walk is ignored.
        step(1'b1, 13'h0020, 13'h0001, 1'b1, 13'h0021, 13'h0002, 1'b0);
        step(1'b1, 13'h0022, 13'h0003, 1'b1, 13'h0023, 13'h0004, 1'b0);
        step(1'b1, 13'h0024, 13'h0005, 1'b0, 13'h0000, 13'h0000, 1'b1);
        chk("inv_wen", wen, 0);
        chk("inv_busy", busy, 1);
        walk_check("walk2", 1'b1);
        chk("inv_drop", drop_cnt, 5);
        idle();
        chk("walk2_end_wen", wen, 0);

        for (int i = 0; i < 1500; i++) rand_step();

        for (int i = 0; i < 300; i++)
            step(1'b1, 13'(13'h0400 + i), 13'(i), 1'b1, 13'(13'h0C00 + i), 13'(i + 7), 1'b0);
        chk("sat_drop", drop_cnt, 255);
        for (int i = 0; i < 5; i++) idle();

        // Reset while the FIFO is draining.
        step(1'b1, 13'h0030, 13'h0011, 1'b1, 13'h0031, 13'h0012, 1'b0);
        step(1'b1, 13'h0032, 13'h0013, 1'b1, 13'h0033, 13'h0014, 1'b0);
        mid_cycle_reset("rst_drain");

        // Reset in the middle of the walk at index 700.
        for (int i = 0; i <= 700; i++) begin
            idle();
            chk("pre_addr", w_addr, i);
        end
        mid_cycle_reset("rst_walk");
        walk_check("walk3", 1'b0);
        idle();
        chk("walk3_end_wen", wen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
